// File: rtl/clk_div_prog.sv
// Runtime-programmable clock divider: registered clk_out with arbitrary period
// and high time. New settings are staged and only take effect at period boundaries.
module clk_div_prog #(
   parameter int CNT_WIDTH = 32,
   parameter int DEF_DIV   = 1000,
   parameter int DEF_HIGH  = 500
) (
   input  logic                 sys_clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic [CNT_WIDTH-1:0] cfg_div,
   input  logic [CNT_WIDTH-1:0] cfg_high,
   input  logic                 cfg_load,
   output logic                 cfg_err,
   output logic                 cfg_pend,
   output logic                 running,
   output logic                 clk_out,
   output logic                 tick
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [CNT_WIDTH-1:0] DIV_RST  = CNT_WIDTH'(DEF_DIV);
   localparam logic [CNT_WIDTH-1:0] HIGH_RST = CNT_WIDTH'(DEF_HIGH);
   localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] TWO      = CNT_WIDTH'(2);

   state_t               state, state_n;
   logic [CNT_WIDTH-1:0] cnt, cnt_n;
   logic [CNT_WIDTH-1:0] div_act, div_n, high_act, high_n;
   logic [CNT_WIDTH-1:0] sh_div, sh_div_n, sh_high, sh_high_n;
   logic                 pend_n, err_n, clk_n;
   logic                 load_ok, last, apply_sh;

   assign running = (state == RUN);

   always_comb begin
      load_ok   = cfg_load && (cfg_div >= TWO) && (cfg_high != '0) && (cfg_high < cfg_div);
      last      = (cnt == div_act - ONE);
      tick      = (state == RUN) && last;
      // The staged setting is consumed in IDLE or at the end of a period.
      apply_sh  = cfg_pend && ((state == IDLE) || last);
      state_n   = state;
      cnt_n     = cnt;
      div_n     = apply_sh ? sh_div  : div_act;
      high_n    = apply_sh ? sh_high : high_act;
      sh_div_n  = load_ok ? cfg_div  : sh_div;
      sh_high_n = load_ok ? cfg_high : sh_high;
      pend_n    = load_ok ? 1'b1 : (apply_sh ? 1'b0 : cfg_pend);
      err_n     = cfg_load && !load_ok;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (en) begin
               state_n = RUN;
               // A load coinciding with start is used by the very first period.
               if (load_ok) begin
                  div_n  = cfg_div;
                  high_n = cfg_high;
                  pend_n = 1'b0;
               end
            end
         end
         RUN: begin
            if (last) begin
               cnt_n = '0;
               if (!en) state_n = IDLE;
            end else begin
               cnt_n = cnt + ONE;
            end
         end
         default: state_n = IDLE;
      endcase
      // Built from next-state values so clk_out is a pure register output.
      clk_n = (state_n == RUN) && (cnt_n < high_n);
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         div_act  <= DIV_RST;
         high_act <= HIGH_RST;
         sh_div   <= DIV_RST;
         sh_high  <= HIGH_RST;
         cfg_pend <= 1'b0;
         cfg_err  <= 1'b0;
         clk_out  <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         div_act  <= div_n;
         high_act <= high_n;
         sh_div   <= sh_div_n;
         sh_high  <= sh_high_n;
         cfg_pend <= pend_n;
         cfg_err  <= err_n;
         clk_out  <= clk_n;
      end
   end

endmodule
